control_sequencer: RTL



---
 rtl/ctrl_pkg.sv | 45 ++++
 rtl/microcode_rom.sv | 73 +++++++
 rtl/control_sequencer.sv | 71 +++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: control-word bit map,
// opcode values and a helper that builds one-hot control bits.
package ctrl_pkg;

  localparam int CW_W = 16;

  // Control-word bit positions
  localparam int HLT = 15;
  localparam int MI  = 14;
  localparam int RI  = 13;
  localparam int RO  = 12;
  localparam int IO  = 11;
  localparam int II  = 10;
  localparam int AI  = 9;
  localparam int AO  = 8;
  localparam int EO  = 7;
  localparam int SU  = 6;
  localparam int BI  = 5;
  localparam int OI  = 4;
  localparam int CE  = 3;
  localparam int CO  = 2;
  localparam int J   = 1;
  localparam int FI  = 0;

  // Opcodes (upper nibble of the instruction register)
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef logic [CW_W-1:0] cw_t;

  // One-hot control bit at position idx
  function automatic cw_t cw_bit(input int idx);
    return cw_t'(16'h0001 << idx);
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode table: (opcode, step, flags) -> control word and
// an end-of-instruction marker. Steps 0 and 1 are the shared fetch.
module microcode_rom
  import ctrl_pkg::*;
#(
  parameter int STEP_W = 3
) (
  input  logic [3:0]        i_opcode,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_flag_c,
  input  logic              i_flag_z,
  output cw_t               o_word,
  output logic              o_last
);

  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

  logic [STEP_W-1:0] w_last_step;

  // Final step index of each opcode; >= compare keeps the counter bounded
  // even if the opcode changes while an instruction is in flight.
  always_comb begin
    w_last_step = T2;
    case (i_opcode)
      OP_LDA, OP_STA: w_last_step = T3;
      OP_ADD, OP_SUB: w_last_step = T4;
      default:        w_last_step = T2;
    endcase
    o_last = (i_step >= w_last_step);
  end

  // Control word for the current step of the current opcode
  always_comb begin
    o_word = '0;
    case (i_step)
      T0: o_word = cw_bit(CO) | cw_bit(MI);
      T1: o_word = cw_bit(RO) | cw_bit(II) | cw_bit(CE);
      T2: begin
        case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: o_word = cw_bit(IO) | cw_bit(MI);
          OP_LDI: o_word = cw_bit(IO) | cw_bit(AI);
          OP_JMP: o_word = cw_bit(IO) | cw_bit(J);
          OP_JC:  o_word = i_flag_c ? (cw_bit(IO) | cw_bit(J)) : '0;
          OP_JZ:  o_word = i_flag_z ? (cw_bit(IO) | cw_bit(J)) : '0;
          OP_OUT: o_word = cw_bit(AO) | cw_bit(OI);
          OP_HLT: o_word = cw_bit(HLT);
          default: o_word = '0;
        endcase
      end
      T3: begin
        case (i_opcode)
          OP_LDA:         o_word = cw_bit(RO) | cw_bit(AI);
          OP_ADD, OP_SUB: o_word = cw_bit(RO) | cw_bit(BI);
          OP_STA:         o_word = cw_bit(AO) | cw_bit(RI);
          default:        o_word = '0;
        endcase
      end
      T4: begin
        case (i_opcode)
          OP_ADD:  o_word = cw_bit(EO) | cw_bit(AI) | cw_bit(FI);
          OP_SUB:  o_word = cw_bit(EO) | cw_bit(AI) | cw_bit(FI) | cw_bit(SU);
          default: o_word = '0;
        endcase
      end
      default: o_word = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: T-state counter, halt latch and run/halt gating of
// the control word produced by the microcode ROM.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 8,
  parameter int STEP_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr,
  input  logic               flag_c,
  input  logic               flag_z,
  output logic [CW_W-1:0]    ctrl,
  output logic [STEP_W-1:0]  step,
  output logic               halted
);

  logic [STEP_W-1:0] r_step;
  logic              r_halted;
  logic [3:0]        w_opcode;
  cw_t               w_word;
  logic              w_last;
  logic              w_unused_operand;

  assign w_opcode         = instr[INSTR_W-1 -: 4];
  // Operand nibble is consumed by the datapath via IO, not by the sequencer
  assign w_unused_operand = ^instr[INSTR_W-5:0];

  microcode_rom #(.STEP_W(STEP_W)) u_rom (
    .i_opcode (w_opcode),
    .i_step   (r_step),
    .i_flag_c (flag_c),
    .i_flag_z (flag_z),
    .o_word   (w_word),
    .o_last   (w_last)
  );

  // Step counter and halt latch; halting freezes the step at T2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step   <= '0;
      r_halted <= 1'b0;
    end else if (run && !r_halted) begin
      if ((r_step == STEP_W'(2)) && (w_opcode == OP_HLT)) begin
        r_halted <= 1'b1;
      end else if (w_last) begin
        r_step <= '0;
      end else begin
        r_step <= r_step + STEP_W'(1);
      end
    end
  end

  // Output gating: paused -> no strobes, halted -> HLT only
  always_comb begin
    ctrl = '0;
    if (!run) begin
      ctrl = '0;
    end else if (r_halted) begin
      ctrl = cw_bit(HLT);
    end else begin
      ctrl = w_word;
    end
  end

  assign step   = r_step;
  assign halted = r_halted;

endmodule
